// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, with a start/done handshake.
// Define SERIAL_SUB_EN to add the 'sub' port (a - b - cin, cout reports borrow).
module serial_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             sub_q, sub_d;
    logic             bit_s, bit_c;
    logic             load_sub;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_SUB_EN
    assign load_sub = sub;
`else
    assign load_sub = 1'b0;
`endif

    // Subtraction reuses the adder: a + ~b + ~cin, with the final carry inverted into a borrow.
    assign b_load = load_sub ? ~b : b;
    assign c_load = load_sub ? ~cin : cin;

    assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        sub_d    = sub_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = c_load;
                    sub_d   = load_sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                carry_d  = bit_c;
                sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                if (cnt_q == LastBit) begin
                    sum_d   = sum_sh_d;
                    cout_d  = sub_q ? ~bit_c : bit_c;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            sub_q    <= sub_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Bench for serial_full_adder: arithmetic/timing model checked every cycle plus directed literals.
// Define SERIAL_SUB_EN to also exercise the subtract mode.
module tb_serial_full_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    serial_full_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Model: an accepted start yields W busy cycles then one done cycle carrying the arithmetic result.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic [W:0]   m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_pend = '0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                {m_cout, m_sum} = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_left = W;
`ifdef SERIAL_SUB_EN
                if (sub) m_pend = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                else     m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`else
                m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`endif
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if (busy !== (m_left > 0) || done !== m_done || sum !== m_sum || cout !== m_cout) begin
            fails++;
            $display("FAIL cycle t=%0t: got busy=%b done=%b sum=%02h cout=%b, want busy=%b done=%b sum=%02h cout=%b",
                     $time, busy, done, sum, cout, (m_left > 0), m_done, m_sum, m_cout);
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        bit found = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check({name, " done seen"}, int'(found), 1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input logic [W-1:0] es, input logic ec);
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(name);
        check({name, " sum"}, int'(sum), int'(es));
        check({name, " cout"}, int'(cout), int'(ec));
    endtask

    initial begin
        int b0, d0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset sum", int'(sum), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // start during busy must be ignored
        @(posedge clk); #1;
        b0 = busy_cnt; d0 = done_cnt;
        start = 1'b1; a = 8'h20; b = 8'h07; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore");
        check("ignore sum", int'(sum), 8'h27);
        check("ignore cout", int'(cout), 0);
        repeat (3) @(posedge clk);
        #1;
        check("ignore busy cycles", busy_cnt - b0, W);
        check("ignore done count", done_cnt - d0, 1);

        // reset mid-run aborts without done
        @(posedge clk); #1;
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort sum", int'(sum), 0);
        check("abort cout", int'(cout), 0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1;
        check("abort no done", done_cnt - d0, 0);
        run_op("12+34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

        // back-to-back with start held high
        @(posedge clk); #1;
        d0 = done_cnt;
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        wait_done("b2b0");
        check("b2b0 sum", int'(sum), 8'h03);
        a = 8'h80; b = 8'h80; cin = 1'b1;
        wait_done("b2b1");
        check("b2b1 sum", int'(sum), 8'h01);
        check("b2b1 cout", int'(cout), 1);
        a = 8'h0F; b = 8'hF0; cin = 1'b1;
        wait_done("b2b2");
        check("b2b2 sum", int'(sum), 8'h00);
        check("b2b2 cout", int'(cout), 1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("b2b3");
        repeat (3) @(posedge clk);
        #1;
        check("b2b done count", done_cnt - d0, 4);

`ifdef SERIAL_SUB_EN
        run_op("10-01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0);
        run_op("00-01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
        run_op("sub0 5a+3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
